// File: rtl/axis_checker_pkg.sv
// Shared definitions for the incrementing-stream checker.
//   - FSM state encoding
//   - AXI-Lite register word offsets (byte address [7:2])
//   - CTRL write bit positions
//   - Throttle LFSR seed, tap mask and step function
//     (used only when AXIS_CHECKER_THROTTLE_EN is defined)
package axis_checker_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [5:0] RegExpInit   = 6'h00;
    localparam logic [5:0] RegExpLen    = 6'h01;
    localparam logic [5:0] RegCtrl      = 6'h02;
    localparam logic [5:0] RegBeatCnt   = 6'h03;
    localparam logic [5:0] RegErrCnt    = 6'h04;
    localparam logic [5:0] RegFirstData = 6'h05;
    localparam logic [5:0] RegFirstIdx  = 6'h06;
    localparam logic [5:0] RegThrottle  = 6'h07;

    localparam int unsigned CtrlArmBit   = 0;
    localparam int unsigned CtrlClearBit = 1;

    localparam logic [15:0] LfsrSeed = 16'hACE1;
    // Taps 16,14,13,11 as bit positions 15,13,12,10.
    localparam logic [15:0] LfsrTaps = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LfsrTaps)};
    endfunction

endpackage

// File: rtl/axis_checker_lite_regs.sv
// AXI4-Lite slave and register file for the incrementing-stream checker.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   s_axi_*               AXI4-Lite slave (full-word access, strobes ignored)
//   arm_o, clear_o        one-cycle command pulses (arm has priority over clear)
//   exp_init_o, exp_len_o burst configuration
//   throttle_en_o         THROTTLE bit0 (only with AXIS_CHECKER_THROTTLE_EN)
//   status_i              {keep_err, tlast_err, done, busy}
//   beat_cnt_i, err_cnt_i, first_err_data_i, first_err_idx_i  read-only counters
// Optional feature macro: AXIS_CHECKER_THROTTLE_EN (adds register 0x1C).
module axis_checker_lite_regs
    import axis_checker_pkg::*;
#(
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [7:0]               s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic                     arm_o,
    output logic                     clear_o,
    output logic [31:0]              exp_init_o,
    output logic [31:0]              exp_len_o,
`ifdef AXIS_CHECKER_THROTTLE_EN
    output logic                     throttle_en_o,
`endif
    input  logic [3:0]               status_i,
    input  logic [31:0]              beat_cnt_i,
    input  logic [ERR_CNT_WIDTH-1:0] err_cnt_i,
    input  logic [31:0]              first_err_data_i,
    input  logic [31:0]              first_err_idx_i
);

    logic        awready_q;
    logic        bvalid_q;
    logic        arready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [31:0] exp_init_q;
    logic [31:0] exp_len_q;
    logic [31:0] rd_mux;
    logic [5:0]  wr_word;
    logic [5:0]  rd_word;
    logic        wr_en;
    logic        ctrl_wr;
`ifdef AXIS_CHECKER_THROTTLE_EN
    logic        throttle_q;
`endif

    assign wr_word = s_axi_awaddr[7:2];
    assign rd_word = s_axi_araddr[7:2];
    // awready and wready rise together, so the write is committed in the ready cycle.
    assign wr_en   = awready_q;
    assign ctrl_wr = wr_en & (wr_word == RegCtrl);

    assign arm_o   = ctrl_wr & s_axi_wdata[CtrlArmBit];
    assign clear_o = ctrl_wr & s_axi_wdata[CtrlClearBit] & ~s_axi_wdata[CtrlArmBit];

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign exp_init_o    = exp_init_q;
    assign exp_len_o     = exp_len_q;
`ifdef AXIS_CHECKER_THROTTLE_EN
    assign throttle_en_o = throttle_q;
`endif

    // Sub-word address bits and strobes carry no information for full-word access.
    logic unused_ok;
    assign unused_ok = ^{s_axi_wstrb, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        rd_mux = '0;
        case (rd_word)
            RegExpInit:   rd_mux = exp_init_q;
            RegExpLen:    rd_mux = exp_len_q;
            RegCtrl:      rd_mux = {28'b0, status_i};
            RegBeatCnt:   rd_mux = beat_cnt_i;
            RegErrCnt:    rd_mux = 32'(err_cnt_i);
            RegFirstData: rd_mux = first_err_data_i;
            RegFirstIdx:  rd_mux = first_err_idx_i;
`ifdef AXIS_CHECKER_THROTTLE_EN
            RegThrottle:  rd_mux = {31'b0, throttle_q};
`endif
            default:      rd_mux = '0;
        endcase
    end

    // Write channel handshake and writable registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            exp_init_q <= '0;
            exp_len_q  <= '0;
`ifdef AXIS_CHECKER_THROTTLE_EN
            throttle_q <= 1'b1;
`endif
        end else begin
            awready_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
            if (wr_en) begin
                bvalid_q <= 1'b1;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (wr_en) begin
                case (wr_word)
                    RegExpInit:  exp_init_q <= s_axi_wdata;
                    RegExpLen:   exp_len_q  <= s_axi_wdata;
`ifdef AXIS_CHECKER_THROTTLE_EN
                    RegThrottle: throttle_q <= s_axi_wdata[0];
`endif
                    default: ;
                endcase
            end
        end
    end

    // Read channel: address accepted and data captured in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= s_axi_arvalid & ~rvalid_q & ~arready_q;
            if (arready_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axis_increment_checker.sv
// AXI4-Stream sink that checks a burst of incrementing 32-bit words against a
// programmed start value and length; configuration and results over AXI4-Lite.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   s_axis_*         AXI4-Stream slave (tkeep must be 4'hF)
//   s_axi_*          AXI4-Lite slave, see axis_checker_lite_regs
// Parameter ERR_CNT_WIDTH: width of the saturating mismatch counter.
// Optional feature macro: AXIS_CHECKER_THROTTLE_EN (LFSR-gated tready).
module axis_increment_checker
    import axis_checker_pkg::*;
#(
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic [7:0]  s_axi_awaddr,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [7:0]  s_axi_araddr,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    state_e                   state_q;
    logic [31:0]              expected_q;
    logic [31:0]              beat_cnt_q;
    logic [31:0]              first_err_data_q;
    logic [31:0]              first_err_idx_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic                     first_seen_q;
    logic                     keep_err_q;
    logic                     tlast_err_q;

    logic        arm;
    logic        clear;
    logic [31:0] exp_init;
    logic [31:0] exp_len;
    logic [3:0]  status;
    logic        beat;
    logic        mismatch;
    logic        last_idx;
    logic        err_sat;

    assign beat     = s_axis_tvalid & s_axis_tready;
    assign mismatch = (s_axis_tdata != expected_q);
    // Compared against the live EXP_LEN so a mid-run change is seen at once.
    assign last_idx = (beat_cnt_q == (exp_len - 32'd1));
    assign err_sat  = &err_cnt_q;
    assign status   = {keep_err_q, tlast_err_q, state_q == StDone, state_q == StRun};

`ifdef AXIS_CHECKER_THROTTLE_EN
    logic [15:0] lfsr_q;
    logic        throttle_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LfsrSeed;
        end else if (arm) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign s_axis_tready = (state_q == StRun) & (~throttle_en | lfsr_q[0]);
`else
    assign s_axis_tready = (state_q == StRun);
`endif

    axis_checker_lite_regs #(
        .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
    ) u_regs (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_axi_awaddr     (s_axi_awaddr),
        .s_axi_awvalid    (s_axi_awvalid),
        .s_axi_awready    (s_axi_awready),
        .s_axi_wdata      (s_axi_wdata),
        .s_axi_wstrb      (s_axi_wstrb),
        .s_axi_wvalid     (s_axi_wvalid),
        .s_axi_wready     (s_axi_wready),
        .s_axi_bresp      (s_axi_bresp),
        .s_axi_bvalid     (s_axi_bvalid),
        .s_axi_bready     (s_axi_bready),
        .s_axi_araddr     (s_axi_araddr),
        .s_axi_arvalid    (s_axi_arvalid),
        .s_axi_arready    (s_axi_arready),
        .s_axi_rdata      (s_axi_rdata),
        .s_axi_rresp      (s_axi_rresp),
        .s_axi_rvalid     (s_axi_rvalid),
        .s_axi_rready     (s_axi_rready),
        .arm_o            (arm),
        .clear_o          (clear),
        .exp_init_o       (exp_init),
        .exp_len_o        (exp_len),
`ifdef AXIS_CHECKER_THROTTLE_EN
        .throttle_en_o    (throttle_en),
`endif
        .status_i         (status),
        .beat_cnt_i       (beat_cnt_q),
        .err_cnt_i        (err_cnt_q),
        .first_err_data_i (first_err_data_q),
        .first_err_idx_i  (first_err_idx_q)
    );

    // FSM, compare and counters. ARM overrides any beat in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            expected_q       <= '0;
            beat_cnt_q       <= '0;
            err_cnt_q        <= '0;
            first_err_data_q <= '0;
            first_err_idx_q  <= '0;
            first_seen_q     <= 1'b0;
            keep_err_q       <= 1'b0;
            tlast_err_q      <= 1'b0;
        end else if (arm) begin
            state_q          <= (exp_len == 32'd0) ? StDone : StRun;
            expected_q       <= exp_init;
            beat_cnt_q       <= '0;
            err_cnt_q        <= '0;
            first_err_data_q <= '0;
            first_err_idx_q  <= '0;
            first_seen_q     <= 1'b0;
            keep_err_q       <= 1'b0;
            tlast_err_q      <= 1'b0;
        end else begin
            // beat only occurs in StRun because tready is gated by the state.
            if (beat) begin
                expected_q <= expected_q + 32'd1;
                beat_cnt_q <= beat_cnt_q + 32'd1;
                if (mismatch && !first_seen_q) begin
                    first_seen_q     <= 1'b1;
                    first_err_data_q <= s_axis_tdata;
                    first_err_idx_q  <= beat_cnt_q;
                end
                if (last_idx || s_axis_tlast) begin
                    state_q <= StDone;
                end
            end
            if (clear) begin
                err_cnt_q   <= '0;
                keep_err_q  <= 1'b0;
                tlast_err_q <= 1'b0;
            end else if (beat) begin
                if (mismatch && !err_sat) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
                if (s_axis_tkeep != 4'hF) begin
                    keep_err_q <= 1'b1;
                end
                // Early tlast or missing final tlast both end the burst here.
                if (s_axis_tlast != last_idx) begin
                    tlast_err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_axis_increment_checker.sv
module tb_axis_increment_checker;

    localparam logic [7:0] AInit  = 8'h00;
    localparam logic [7:0] ALen   = 8'h04;
    localparam logic [7:0] ACtrl  = 8'h08;
    localparam logic [7:0] ABeat  = 8'h0C;
    localparam logic [7:0] AErr   = 8'h10;
    localparam logic [7:0] AFData = 8'h14;
    localparam logic [7:0] AFIdx  = 8'h18;
    localparam logic [7:0] AThr   = 8'h1C;
    localparam int         Limit  = 400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [3:0]  s_axis_tkeep = 4'hF;
    logic        s_axis_tlast = 1'b0;
    logic [7:0]  s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = 4'hF;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [7:0]  s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;

    axis_increment_checker #(
        .ERR_CNT_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rdy_hi = 0;
    int cyc = 0;
    always @(negedge clk) if (s_axis_tready) rdy_hi++;
    always @(posedge clk) cyc++;

    logic [31:0] rv;

    // Burst under test and the reference expectations derived from it.
    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    bit          q_last[$];
    int          m_acc;
    int          m_errs;
    logic [31:0] m_fdata;
    logic [31:0] m_fidx;
    bit          m_tle;
    bit          m_ke;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // A word is good when it equals init + its position; the burst ends at
    // position len-1 or at the first tlast, whichever comes first.
    task automatic model(input logic [31:0] init, input logic [31:0] len);
        bit fin;
        m_acc = 0; m_errs = 0; m_fdata = 0; m_fidx = 0; m_tle = 0; m_ke = 0;
        for (int i = 0; i < q_data.size(); i++) begin
            fin = (32'(i) == len - 32'd1);
            m_acc++;
            if (q_data[i] != init + 32'(i)) begin
                if (m_errs == 0) begin
                    m_fdata = q_data[i];
                    m_fidx  = 32'(i);
                end
                m_errs++;
            end
            if (q_keep[i] != 4'hF) m_ke = 1;
            if (fin || q_last[i]) begin
                m_tle = (q_last[i] != fin);
                break;
            end
        end
    endtask

    task automatic gen_clean(input logic [31:0] init, input int len);
        q_data.delete(); q_keep.delete(); q_last.delete();
        for (int i = 0; i < len; i++) begin
            q_data.push_back(init + 32'(i));
            q_keep.push_back(4'hF);
            q_last.push_back(i == len - 1);
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input bit collide);
        int n;
        n = 0;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_awvalid = 1; s_axi_wvalid = 1;
        do begin @(posedge clk); #1; n++; end while (!s_axi_awready && n < Limit);
        chk("aw_wait", 32'(n < Limit), 1);
        chk("wready_with_awready", 32'(s_axi_wready), 1);
        if (collide) begin
            // Offer a wrong, tlast-marked beat on the edge where ARM lands.
            s_axis_tdata = 32'hBADBAD00; s_axis_tkeep = 4'hF; s_axis_tlast = 1;
            s_axis_tvalid = 1;
        end
        @(posedge clk); #1;
        s_axis_tvalid = 0; s_axis_tlast = 0;
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        n = 0;
        while (!s_axi_bvalid && n < Limit) begin @(posedge clk); #1; n++; end
        chk("b_wait", 32'(n < Limit), 1);
        s_axi_bready = 1;
        @(posedge clk); #1;
        s_axi_bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] a);
        int n;
        n = 0;
        s_axi_araddr = a; s_axi_arvalid = 1;
        do begin @(posedge clk); #1; n++; end while (!s_axi_arready && n < Limit);
        chk("ar_wait", 32'(n < Limit), 1);
        @(posedge clk); #1;
        s_axi_arvalid = 0;
        n = 0;
        while (!s_axi_rvalid && n < Limit) begin @(posedge clk); #1; n++; end
        chk("r_wait", 32'(n < Limit), 1);
        rv = s_axi_rdata;
        s_axi_rready = 1;
        @(posedge clk); #1;
        s_axi_rready = 0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input bit l);
        int n;
        n = 0;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1;
        while (!s_axis_tready && n < Limit) begin @(posedge clk); #1; n++; end
        chk("tready_wait", 32'(n < Limit), 1);
        @(posedge clk); #1;
        s_axis_tvalid = 0; s_axis_tlast = 0;
    endtask

    task automatic feed_and_check(input string name);
        for (int i = 0; i < m_acc; i++) send_beat(q_data[i], q_keep[i], q_last[i]);
        chk({name, "_tready_after"}, 32'(s_axis_tready), 0);
        axi_read(ACtrl);
        chk({name, "_status"}, rv, 32'({m_ke, m_tle, 2'b10}));
        axi_read(ABeat);
        chk({name, "_beat_cnt"}, rv, 32'(m_acc));
        axi_read(AErr);
        chk({name, "_err_cnt"}, rv, 32'(m_errs));
        if (m_errs > 0) begin
            axi_read(AFData);
            chk({name, "_first_data"}, rv, m_fdata);
            axi_read(AFIdx);
            chk({name, "_first_idx"}, rv, m_fidx);
        end
    endtask

    task automatic run_burst(input logic [31:0] init, input logic [31:0] len, input string name);
        model(init, len);
        axi_write(AInit, init, 0);
        axi_write(ALen, len, 0);
        axi_write(ACtrl, 32'h1, 0);
        axi_read(ACtrl);
        chk({name, "_busy"}, rv, 32'h1);
        feed_and_check(name);
    endtask

    initial begin
        int len, mode, early, c0;
        logic [31:0] init;

        // Reset state
        #1;
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_awready", 32'(s_axi_awready), 0);
        chk("rst_bvalid", 32'(s_axi_bvalid), 0);
        chk("rst_rvalid", 32'(s_axi_rvalid), 0);
        chk("rst_rdata", s_axi_rdata, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        axi_read(ACtrl);
        chk("rst_status", rv, 0);
        axi_read(ABeat);
        chk("rst_beat_cnt", rv, 0);
        chk("rresp", 32'(s_axi_rresp), 0);
        axi_read(8'h20);
        chk("unmapped_read", rv, 0);

        // Clean 8-beat burst
        gen_clean(32'h10, 8);
        run_burst(32'h10, 8, "clean8");

        // Fourth word corrupted, then CLEAR
        gen_clean(32'h10, 8);
        q_data[3] = 32'hDEAD;
        run_burst(32'h10, 8, "corrupt");
        axi_write(ACtrl, 32'h2, 0);
        axi_read(ACtrl);
        chk("clear_status", rv, 32'h2);
        axi_read(AErr);
        chk("clear_err_cnt", rv, 0);
        axi_read(ABeat);
        chk("clear_beat_kept", rv, 8);

        // Early tlast, then missing tlast
        gen_clean(32'h40, 4);
        q_last[1] = 1; q_last[3] = 0;
        run_burst(32'h40, 4, "early_tlast");
        gen_clean(32'h40, 4);
        q_last[3] = 0;
        run_burst(32'h40, 4, "missing_tlast");

        // Data wrap at 2^32
        gen_clean(32'hFFFF_FFFE, 4);
        run_burst(32'hFFFF_FFFE, 4, "wrap");

        // Zero-length burst
        axi_write(ALen, 0, 0);
        c0 = rdy_hi;
        axi_write(ACtrl, 32'h1, 0);
        repeat (4) @(posedge clk);
        #1;
        axi_read(ACtrl);
        chk("len0_status", rv, 32'h2);
        chk("len0_no_tready", 32'(rdy_hi - c0), 0);

        // Re-ARM mid-burst with a colliding beat; new burst must pass
        axi_write(AInit, 32'h100, 0);
        axi_write(ALen, 8, 0);
        axi_write(ACtrl, 32'h1, 0);
        send_beat(32'h100, 4'hF, 0);
        send_beat(32'h101, 4'hF, 0);
        axi_write(AInit, 32'h200, 0);
        gen_clean(32'h200, 8);
        model(32'h200, 8);
        axi_write(ACtrl, 32'h3, 1);
        axi_read(ABeat);
        chk("rearm_beat_restart", rv, 0);
        feed_and_check("rearm");

        // Asynchronous reset mid-burst
        gen_clean(32'h5, 8);
        axi_write(AInit, 32'h5, 0);
        axi_write(ALen, 8, 0);
        axi_write(ACtrl, 32'h1, 0);
        send_beat(32'h5, 4'hF, 0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_tready", 32'(s_axis_tready), 0);
        @(posedge clk); #1 rst_n = 1;
        axi_read(ACtrl);
        chk("async_rst_status", rv, 0);

        // Randomised bursts
        for (int it = 0; it < 24; it++) begin
            init = $urandom;
            if (it % 6 == 0) init = 32'hFFFF_FFF8;
            len = int'($urandom_range(1, 12));
            mode = (len >= 2) ? int'($urandom_range(0, 2)) : 0;
            early = (len >= 2) ? int'($urandom_range(0, len - 2)) : 0;
            q_data.delete(); q_keep.delete(); q_last.delete();
            for (int i = 0; i < len; i++) begin
                q_data.push_back(($urandom_range(0, 5) == 0) ? $urandom : init + 32'(i));
                q_keep.push_back(($urandom_range(0, 11) == 0) ? 4'h7 : 4'hF);
                q_last.push_back(mode == 0 ? (i == len - 1) : (mode == 1 ? (i == early) : 1'b0));
            end
            run_burst(init, 32'(len), $sformatf("rand%0d", it));
        end

`ifdef AXIS_CHECKER_THROTTLE_EN
        axi_read(AThr);
        chk("thr_reset", rv, 1);
        gen_clean(32'h1000, 64);
        c0 = cyc;
        run_burst(32'h1000, 64, "thr64");
        chk("thr_stalls_seen", 32'((cyc - c0) > 64 + 40), 1);
        axi_write(AThr, 0, 0);
        gen_clean(32'h2000, 16);
        model(32'h2000, 16);
        axi_write(AInit, 32'h2000, 0);
        axi_write(ALen, 16, 0);
        axi_write(ACtrl, 32'h1, 0);
        c0 = rdy_hi;
        feed_and_check("thr_off");
        chk("thr_off_tready_cycles", 32'(rdy_hi - c0), 16);
`else
        axi_write(AThr, 32'h1, 0);
        axi_read(AThr);
        chk("thr_absent", rv, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
